// File: rtl/stage_execute.sv
// -----------------------------------------------------------------------------
// stage_execute
//
// Execute stage of an in-order RV32IM pipeline, between decode and memory.
// ALU and multiply ops finish in one cycle. DIV/DIVU/REM/REMU use an
// iterative restoring divider that takes DIV_ITERS cycles; divide-by-zero and
// signed overflow are resolved in one cycle without entering the divider.
// Branches and jumps produce a one-shot combinational redirect to fetch.
// Results and memory controls are registered into the mem_* pipeline
// registers.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   ex_valid                   decode presents a valid instruction
//   ex_pc                      instruction PC
//   ex_op                      operation select (0..17, 18..31 act as ADD)
//   ex_data0, ex_data1         operands A and B
//   ex_store_data              store data, passed to mem_data1
//   ex_branch, ex_jump         conditional branch / JAL-JALR
//   ex_br_cond                 branch funct3
//   ex_cmp0, ex_cmp1           branch compare operands
//   ex_target                  branch/jump target
//   ex_read/write/extend/width memory controls, passed through
//   ex_reg                     destination register
//   mem_stall                  memory stage cannot accept
//   ex_stall                   decode must hold all ex_* inputs
//   redir_valid, redir_pc      fetch redirect
//   mem_*, wb_reg              registered outputs to the memory stage
// -----------------------------------------------------------------------------
module stage_execute #(
  parameter int ENABLE_M  = 1,
  parameter int DIV_ITERS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [4:0]  ex_op,
  input  logic [31:0] ex_data0,
  input  logic [31:0] ex_data1,
  input  logic [31:0] ex_store_data,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic [2:0]  ex_br_cond,
  input  logic [31:0] ex_cmp0,
  input  logic [31:0] ex_cmp1,
  input  logic [31:0] ex_target,
  input  logic        ex_read,
  input  logic        ex_write,
  input  logic        ex_extend,
  input  logic [1:0]  ex_width,
  input  logic [4:0]  ex_reg,
  input  logic        mem_stall,
  output logic        ex_stall,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  output logic        mem_valid,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_data0,
  output logic [31:0] mem_data1,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_extend,
  output logic [1:0]  mem_width,
  output logic [4:0]  wb_reg
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic       M_ON      = (ENABLE_M != 0);
  localparam logic [5:0] LAST_ITER = 6'(DIV_ITERS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;

  // Divider datapath: quotient shifts in from the bottom while the dividend
  // magnitude shifts out of the top of the same register.
  logic [31:0] quot_q, rem_q, dvs_q;
  logic        q_neg_q, r_neg_q;

  logic [31:0] a, b;
  logic        is_m, is_div, div_signed, div_is_rem;
  logic        div_by_zero, div_ovf, div_special, div_start, div_pending;
  logic [31:0] dvd_abs, dvs_abs;
  logic [32:0] div_shift, div_diff;
  logic [31:0] quot_fix, rem_fix, div_res;
  logic        mul_sa, mul_sb;
  logic [63:0] mul_a, mul_b, mul_p;
  logic [31:0] op_res;
  logic        taken;

  assign a = ex_data0;
  assign b = ex_data1;

  assign is_m       = (ex_op >= OP_MUL) && (ex_op <= OP_REMU);
  assign is_div     = (ex_op >= OP_DIV) && (ex_op <= OP_REMU);
  assign div_signed = (ex_op == OP_DIV) || (ex_op == OP_REM);
  assign div_is_rem = (ex_op == OP_REM) || (ex_op == OP_REMU);

  assign div_by_zero = (b == 32'd0);
  assign div_ovf     = div_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign div_special = div_by_zero || div_ovf;

  assign div_start   = M_ON && ex_valid && is_div && !div_special && (state_q == IDLE);
  assign div_pending = M_ON && (((state_q == IDLE) && is_div && !div_special) ||
                                (state_q == BUSY));

  assign ex_stall    = ex_valid && (mem_stall || div_pending);

  // ---------------------------------------------------------------------------
  // Divider FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (div_start) begin
        state_d = BUSY;
        cnt_d   = 6'd0;
      end
      BUSY: begin
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_ITER) state_d = DONE;
      end
      DONE: if (!ex_stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dvd_abs   = (div_signed && a[31]) ? -a : a;
  assign dvs_abs   = (div_signed && b[31]) ? -b : b;
  assign div_shift = {rem_q, quot_q[31]};
  assign div_diff  = div_shift - {1'b0, dvs_q};

  // NOTE: the divider datapath has no reset; it is always loaded on start
  // and only read in DONE, so its power-up contents never matter.
  always_ff @(posedge clk) begin
    if (div_start) begin
      quot_q  <= dvd_abs;
      rem_q   <= 32'd0;
      dvs_q   <= dvs_abs;
      q_neg_q <= div_signed && (a[31] ^ b[31]);
      r_neg_q <= div_signed && a[31];
    end else if (state_q == BUSY) begin
      // Restoring step: keep the subtraction only when it did not borrow.
      quot_q <= {quot_q[30:0], ~div_diff[32]};
      rem_q  <= div_diff[32] ? div_shift[31:0] : div_diff[31:0];
    end
  end

  assign quot_fix = q_neg_q ? -quot_q : quot_q;
  assign rem_fix  = r_neg_q ? -rem_q  : rem_q;

  always_comb begin
    div_res = div_is_rem ? rem_fix : quot_fix;
    if (state_q != DONE) begin
      if (div_by_zero) div_res = div_is_rem ? a : 32'hFFFF_FFFF;
      else             div_res = div_is_rem ? 32'd0 : 32'h8000_0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Multiplier: sign-extending to 64 bits lets one unsigned product serve
  // all four MUL variants.
  // ---------------------------------------------------------------------------
  assign mul_sa = (ex_op == OP_MULH) || (ex_op == OP_MULHSU);
  assign mul_sb = (ex_op == OP_MULH);
  assign mul_a  = {{32{mul_sa & a[31]}}, a};
  assign mul_b  = {{32{mul_sb & b[31]}}, b};
  assign mul_p  = mul_a * mul_b;

  // ---------------------------------------------------------------------------
  // Result select
  // ---------------------------------------------------------------------------
  always_comb begin
    op_res = a + b;
    case (ex_op)
      OP_SUB:    op_res = a - b;
      OP_SLL:    op_res = a << b[4:0];
      OP_SLT:    op_res = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU:   op_res = {31'd0, a < b};
      OP_XOR:    op_res = a ^ b;
      OP_SRL:    op_res = a >> b[4:0];
      OP_SRA:    op_res = $unsigned($signed(a) >>> b[4:0]);
      OP_OR:     op_res = a | b;
      OP_AND:    op_res = a & b;
      OP_MUL:    op_res = mul_p[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  op_res = mul_p[63:32];
      OP_DIV,
      OP_DIVU,
      OP_REM,
      OP_REMU:   op_res = div_res;
      default:   op_res = a + b;
    endcase
    if (!M_ON && is_m) op_res = 32'd0;
  end

  // ---------------------------------------------------------------------------
  // Branch resolution and redirect
  // ---------------------------------------------------------------------------
  always_comb begin
    taken = 1'b0;
    case (ex_br_cond)
      3'd0: taken = (ex_cmp0 == ex_cmp1);
      3'd1: taken = (ex_cmp0 != ex_cmp1);
      3'd4: taken = ($signed(ex_cmp0) <  $signed(ex_cmp1));
      3'd5: taken = ($signed(ex_cmp0) >= $signed(ex_cmp1));
      3'd6: taken = (ex_cmp0 <  ex_cmp1);
      3'd7: taken = (ex_cmp0 >= ex_cmp1);
      default: taken = 1'b0;
    endcase
  end

  // Gating with ex_stall makes the redirect fire only in the cycle the
  // instruction leaves execute, hence exactly once.
  assign redir_valid = ex_valid && !ex_stall && (ex_jump || (ex_branch && taken));
  assign redir_pc    = ex_target;

  // ---------------------------------------------------------------------------
  // Pipeline registers to the memory stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_valid  <= 1'b0;
      mem_pc     <= 32'd0;
      mem_data0  <= 32'd0;
      mem_data1  <= 32'd0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_extend <= 1'b0;
      mem_width  <= 2'd0;
      wb_reg     <= 5'd0;
    end else if (!mem_stall) begin
      mem_valid  <= ex_valid && !ex_stall;
      mem_pc     <= ex_pc;
      mem_data0  <= ex_jump ? (ex_pc + 32'd4) : op_res;
      mem_data1  <= ex_store_data;
      mem_read   <= ex_read;
      mem_write  <= ex_write;
      mem_extend <= ex_extend;
      mem_width  <= ex_width;
      wb_reg     <= ex_reg;
    end
  end

  // Only a 32-iteration divider produces a full quotient.
  assert property (@(posedge clk) DIV_ITERS == 32);

endmodule

// File: tb/tb_stage_execute.sv
// -----------------------------------------------------------------------------
// tb_stage_execute
//
// Directed testbench for stage_execute. Each issued instruction pushes its
// hand-computed mem_* contents onto a scoreboard queue; a monitor pops and
// compares whenever the memory stage consumes a valid output
// (mem_valid & ~mem_stall). Stall counts and redirects are checked inline.
// -----------------------------------------------------------------------------
module tb_stage_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_op;
  logic [31:0] ex_data0, ex_data1, ex_store_data;
  logic        ex_branch, ex_jump;
  logic [2:0]  ex_br_cond;
  logic [31:0] ex_cmp0, ex_cmp1, ex_target;
  logic        ex_read, ex_write, ex_extend;
  logic [1:0]  ex_width;
  logic [4:0]  ex_reg;
  logic        mem_stall;
  logic        ex_stall;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        mem_valid;
  logic [31:0] mem_pc, mem_data0, mem_data1;
  logic        mem_read, mem_write, mem_extend;
  logic [1:0]  mem_width;
  logic [4:0]  wb_reg;

  always #5 clk = ~clk;

  stage_execute dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_op(ex_op), .ex_data0(ex_data0), .ex_data1(ex_data1),
    .ex_store_data(ex_store_data), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_br_cond(ex_br_cond), .ex_cmp0(ex_cmp0), .ex_cmp1(ex_cmp1),
    .ex_target(ex_target), .ex_read(ex_read), .ex_write(ex_write),
    .ex_extend(ex_extend), .ex_width(ex_width), .ex_reg(ex_reg),
    .mem_stall(mem_stall), .ex_stall(ex_stall), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .mem_valid(mem_valid), .mem_pc(mem_pc),
    .mem_data0(mem_data0), .mem_data1(mem_data1), .mem_read(mem_read),
    .mem_write(mem_write), .mem_extend(mem_extend), .mem_width(mem_width),
    .wb_reg(wb_reg)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        rd;
    logic        wr;
    logic        ext;
    logic [1:0]  w;
    logic [4:0]  rg;
  } exp_t;

  exp_t sb[$];
  int   n_vec       = 0;
  int   n_miss      = 0;
  int   redir_total = 0;
  int   n           = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (redir_valid) redir_total++;
    if (!reset && mem_valid && !mem_stall) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_output: mem_pc %h with empty scoreboard", mem_pc);
      end else begin
        e = sb.pop_front();
        check("mem_pc",    mem_pc,    e.pc);
        check("mem_data0", mem_data0, e.d0);
        check("mem_data1", mem_data1, e.d1);
        check("mem_ctl",
              {22'd0, mem_read, mem_write, mem_extend, mem_width, wb_reg},
              {22'd0, e.rd, e.wr, e.ext, e.w, e.rg});
      end
    end
  end

  // Loads a fresh instruction; side fields vary with the instruction count
  // so pass-through mistakes show up.
  task automatic setup(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_pc         = 32'h1000 + 32'(n * 4);
    ex_op         = op;
    ex_data0      = a;
    ex_data1      = b;
    ex_store_data = 32'hA5A5_0000 ^ 32'(n * 3);
    ex_branch     = 1'b0;
    ex_jump       = 1'b0;
    ex_br_cond    = 3'd0;
    ex_cmp0       = 32'd0;
    ex_cmp1       = 32'd0;
    ex_target     = 32'd0;
    ex_read       = n[0];
    ex_write      = n[1];
    ex_extend     = n[2];
    ex_width      = 2'(n);
    ex_reg        = 5'(n + 1);
  endtask

  task automatic push_exp(input logic [31:0] d0);
    exp_t e;
    e.pc  = ex_pc;
    e.d0  = d0;
    e.d1  = ex_store_data;
    e.rd  = ex_read;
    e.wr  = ex_write;
    e.ext = ex_extend;
    e.w   = ex_width;
    e.rg  = ex_reg;
    sb.push_back(e);
  endtask

  // Presents the prepared instruction until accepted, counting stall
  // cycles and redirect pulses along the way.
  task automatic issue(input logic [31:0] d0, input int exp_stalls,
                       input int exp_redir, input string name);
    int stalls = 0;
    int pulses = 0;
    push_exp(d0);
    ex_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (redir_valid) begin
        pulses++;
        check({name, "_redir_pc"}, redir_pc, ex_target);
      end
      if (!ex_stall) break;
      stalls++;
      if (stalls > 200) begin
        n_vec++;
        n_miss++;
        $display("FAIL %s_timeout: ex_stall still high after %0d cycles", name, stalls);
        break;
      end
    end
    check({name, "_stalls"}, 32'(stalls), 32'(exp_stalls));
    check({name, "_redir"},  32'(pulses), 32'(exp_redir));
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    n++;
  endtask

  task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int stalls, input string name);
    setup(op, a, b);
    issue(exp, stalls, 0, name);
  endtask

  task automatic branch(input logic [2:0] cond, input logic [31:0] c0, input logic [31:0] c1,
                        input int exp_taken, input string name);
    setup(5'd0, 32'd0, 32'd0);
    ex_branch  = 1'b1;
    ex_br_cond = cond;
    ex_cmp0    = c0;
    ex_cmp1    = c1;
    ex_target  = 32'h300 + 32'(n * 16);
    issue(32'd0, 0, exp_taken, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r0;
    reset     = 1'b1;
    ex_valid  = 1'b0;
    mem_stall = 1'b0;
    setup(5'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_data0", mem_data0, 32'd0);
    check("rst_mem_pc",    mem_pc,    32'd0);
    check("rst_wb_reg",    {27'd0, wb_reg}, 32'd0);
    check("rst_ex_stall",  {31'd0, ex_stall}, 32'd0);
    @(posedge clk);
    #1;

    // Single-cycle ALU / multiply
    alu(5'd0,  32'd5,          32'd7,          32'd12,         0, "add");
    alu(5'd1,  32'd5,          32'd7,          32'hFFFF_FFFE,  0, "sub");
    alu(5'd3,  32'hFFFF_FFFF,  32'd1,          32'd1,          0, "slt");
    alu(5'd4,  32'hFFFF_FFFF,  32'd1,          32'd0,          0, "sltu");
    alu(5'd5,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0,  0, "xor");
    alu(5'd8,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  0, "or");
    alu(5'd9,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  0, "and");
    alu(5'd2,  32'd1,          32'd33,         32'd2,          0, "sll");
    alu(5'd6,  32'h8000_0000,  32'd35,         32'h1000_0000,  0, "srl");
    alu(5'd7,  32'h8000_0000,  32'd35,         32'hF000_0000,  0, "sra");
    alu(5'd20, 32'hFFFF_FFFF,  32'd2,          32'd1,          0, "op20_add");
    alu(5'd10, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          0, "mul");
    alu(5'd11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd0,          0, "mulh");
    alu(5'd12, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  0, "mulhsu");
    alu(5'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  0, "mulhu");

    // Iterative divide
    alu(5'd14, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33, "div_m7_2");
    alu(5'd16, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33, "rem_m7_2");
    alu(5'd14, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD, 33, "div_7_m2");
    alu(5'd16, 32'd7,          32'hFFFF_FFFE,  32'd1,         33, "rem_7_m2");
    alu(5'd15, 32'd100,        32'd7,          32'd14,        33, "divu_100_7");
    alu(5'd17, 32'd100,        32'd7,          32'd2,         33, "remu_100_7");
    alu(5'd14, 32'h8000_0000,  32'd2,          32'hC000_0000, 33, "div_min_2");

    // One-cycle special cases
    alu(5'd15, 32'd100,        32'd0,          32'hFFFF_FFFF,  0, "divu_by0");
    alu(5'd17, 32'd100,        32'd0,          32'd100,        0, "remu_by0");
    alu(5'd14, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, "div_ovf");
    alu(5'd16, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, "rem_ovf");

    // Branches and jump
    branch(3'd0, 32'd5,         32'd5,         1, "beq_t");
    branch(3'd0, 32'd3,         32'd4,         0, "beq_nt");
    branch(3'd5, 32'hFFFF_FFFF, 32'd1,         0, "bge_nt");
    branch(3'd6, 32'd1,         32'hFFFF_FFFF, 1, "bltu_t");
    branch(3'd2, 32'd5,         32'd5,         0, "cond2_nt");
    setup(5'd0, 32'd9, 32'd9);
    ex_jump   = 1'b1;
    ex_target = 32'h400;
    issue(ex_pc + 32'd4, 0, 1, "jal");

    // BNE behind an ADD, with mem_stall high for two cycles
    alu(5'd0, 32'd10, 32'd20, 32'd30, 0, "add_before_bne");
    r0 = redir_total;
    setup(5'd1, 32'd3, 32'd4);
    ex_branch  = 1'b1;
    ex_br_cond = 3'd1;
    ex_cmp0    = 32'd3;
    ex_cmp1    = 32'd4;
    ex_target  = 32'h200;
    push_exp(32'hFFFF_FFFF);
    ex_valid  = 1'b1;
    mem_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("bne_hold_valid", {31'd0, mem_valid}, 32'd1);
      check("bne_hold_data0", mem_data0, 32'd30);
      check("bne_hold_redir", {31'd0, redir_valid}, 32'd0);
      check("bne_hold_stall", {31'd0, ex_stall}, 32'd1);
      @(posedge clk);
      #1;
    end
    mem_stall = 1'b0;
    @(negedge clk);
    check("bne_redir",    {31'd0, redir_valid}, 32'd1);
    check("bne_redir_pc", redir_pc, 32'h200);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    n++;
    @(negedge clk);
    check("bne_redir_once", 32'(redir_total - r0), 32'd1);
    @(posedge clk);
    #1;

    // mem_stall raised mid-divide and held past completion
    setup(5'd15, 32'd1000, 32'd3);
    push_exp(32'd333);
    ex_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    mem_stall = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    @(negedge clk);
    check("divstall_held_stall", {31'd0, ex_stall}, 32'd1);
    check("divstall_no_output",  {31'd0, mem_valid}, 32'd0);
    @(posedge clk);
    #1;
    mem_stall = 1'b0;
    @(negedge clk);
    check("divstall_release", {31'd0, ex_stall}, 32'd0);
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
    n++;

    // Reset during iteration 10 of a divide aborts it
    setup(5'd14, 32'hFFFF_FFF9, 32'd2);
    ex_valid = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    ex_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_mem_valid", {31'd0, mem_valid}, 32'd0);
    @(posedge clk);
    #1;
    n++;
    alu(5'd0, 32'd1, 32'd1, 32'd2, 0, "add_after_abort");

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/stage_execute.md
Name: stage_execute

Overview:
Execute stage of the in-order RV32IM pipeline. It sits between decode and the memory stage. It computes ALU and multiply results in one cycle and divide/remainder results with an iterative 32-cycle divider. It resolves branches and jumps, issuing a one-shot redirect to fetch. Results and memory controls are registered into the mem_* pipeline registers that the memory stage consumes.

Parameters:
ENABLE_M, 1, when 0 ops 10-17 produce result 0 in one cycle and never stall.
DIV_ITERS, 32, number of divider iterations; only 32 is legal, asserted in simulation.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ex_valid  in  1  decode presents a valid instruction
ex_pc  in  32  instruction PC
ex_op  in  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU; 18-31 treated as ADD
ex_data0  in  32  operand A (rs1 or PC)
ex_data1  in  32  operand B (rs2 or immediate)
ex_store_data  in  32  rs2 value for stores
ex_branch  in  1  conditional branch
ex_jump  in  1  JAL/JALR
ex_br_cond  in  3  funct3: 0 EQ, 1 NE, 4 LT, 5 GE, 6 LTU, 7 GEU; 2/3 never taken
ex_cmp0, ex_cmp1  in  32 each  branch compare operands
ex_target  in  32  branch/jump target, computed by decode
ex_read, ex_write, ex_extend  in  1 each  memory controls, passed through
ex_width  in  2  memory width, passed through
ex_reg  in  5  destination register
mem_stall  in  1  memory stage cannot accept
ex_stall  out  1  decode must hold all ex_* inputs stable
redir_valid  out  1  fetch redirect, combinational
redir_pc  out  32  redirect target (= ex_target)
mem_valid  out  1  registered
mem_pc  out  32  registered
mem_data0  out  32  registered result or address
mem_data1  out  32  registered store data
mem_read, mem_write, mem_extend  out  1 each  registered
mem_width  out  2  registered
wb_reg  out  5  registered destination register

Behaviour:
- Reset: mem_valid=0; divider state returns to IDLE; all other mem_* registers are 0. Reset during a division aborts it, and no result is produced.
- Divider FSM states: IDLE, BUSY, DONE.
  - IDLE→BUSY when ex_valid and a div op with divisor≠0 and not signed overflow.
  - BUSY runs for DIV_ITERS cycles using a 6-bit counter, restoring one bit per cycle on magnitudes, then →DONE.
  - DONE→IDLE on the cycle the result is accepted (ex_stall=0).
  - Signs are fixed up at DONE: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
- Divider special cases complete in one cycle, without entering BUSY:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend.
  - DIV/REM of 0x80000000 by 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- Stall: ex_stall = ex_valid & (mem_stall | div_pending). div_pending is high in IDLE when a div op is about to start (non-special), and high in BUSY. Divide latency is therefore 34 cycles from ex_valid to the mem_* load, with mem_stall low.
- Pipeline register update:
  - If mem_stall=1, hold all mem_* registers.
  - Otherwise mem_valid <= ex_valid & ~ex_stall, and the remaining mem_* registers load every unstalled cycle. Their contents are don't-care when mem_valid=0.
- mem_data0 selection: ex_pc+4 if ex_jump; otherwise the op result.
- mem_data1 = ex_store_data. The other mem_* outputs mirror their ex_* inputs.
- Arithmetic rules:
  - Shifts use only data1[4:0]; SRA is arithmetic.
  - SLT/SLTU give 0/1.
  - MUL gives the low 32 bits of the 64-bit product. MULH, MULHSU and MULHU give the high 32 bits with operands signed/signed, signed/unsigned and unsigned/unsigned respectively.
  - All arithmetic wraps modulo 2^32.
- Redirect:
  - redir_valid = ex_valid & ~ex_stall & (ex_jump | (ex_branch & taken)).
  - It fires exactly once per instruction, in the cycle the instruction moves to mem. It is suppressed while mem_stall is high.
- Simultaneous events:
  - mem_stall rising while in DONE: hold the result in DONE, with no recomputation.
  - mem_stall rising mid-BUSY: iterations continue.

Test Plan:
- ADD 5+7, mem_stall=0 → next cycle mem_valid=1, mem_data0=12, ex_stall never high.
- DIV 0xFFFFFFF9 (−7) by 2 → ex_stall high 33 cycles; mem_data0=0xFFFFFFFD. REM of the same operands → 0xFFFFFFFF.
- DIVU 100 by 0 → no stall, mem_data0=0xFFFFFFFF. DIV 0x80000000 by 0xFFFFFFFF → 0x80000000.
- BNE 3 vs 4, target 0x200, mem_stall high 2 cycles then low → redir_valid pulses once, in the cycle mem_stall falls, with redir_pc=0x200. mem_* registers held during the stall.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULH of the same → 0. SRA 0x80000000 by 35 → 0xF0000000.
- Reset asserted at iteration 10 of a DIV → mem_valid=0 and FSM in IDLE. A subsequent ADD 1+1 completes with mem_data0=2 in one cycle.
